// File: rtl/pipe_pkg.sv
// pipe_pkg: state encoding and default wait limit shared by the pipeline controller.
package pipe_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FAULT = 2'd2} state_e;
  localparam int WAIT_MAX_DEF = 15;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard between the ID sources and the EX load destination.
module hazard_detect (
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic [4:0] rd_i,
  input  logic       use_rs1_i,
  input  logic       use_rs2_i,
  input  logic       load_i,
  output logic       hazard_o
);
  assign hazard_o = load_i & (rd_i != 5'd0) &
                    ((use_rs1_i & (rs1_i == rd_i)) | (use_rs2_i & (rs2_i == rd_i)));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/freeze control for a 5-stage pipeline with data-memory wait timeout.
// Define PIPE_CTRL_PERF_EN to add saturating load-use, branch-flush and memory-wait counters.
module pipe_ctrl import pipe_pkg::*; #(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_load,
  input  logic        ex_br_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        mem_wb_bubble,
  output logic [1:0]  state,
`ifdef PIPE_CTRL_PERF_EN
  output logic        mem_timeout,
  output logic [31:0] lu_stall_cnt,
  output logic [31:0] br_flush_cnt,
  output logic [31:0] mem_wait_cnt
`else
  output logic        mem_timeout
`endif
);
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       to_q, to_d;
  logic       hazard, frozen, fault, run_ok, lu, br;
  hazard_detect u_hazard (
    .rs1_i(id_rs1), .rs2_i(id_rs2), .rd_i(ex_rd),
    .use_rs1_i(id_use_rs1), .use_rs2_i(id_use_rs2), .load_i(ex_load),
    .hazard_o(hazard)
  );
  // A release cycle out of MEM_WAIT is evaluated exactly like RUN.
  assign frozen = (state_q == MEM_WAIT) ? !mem_ready : (state_q == RUN) & mem_req & !mem_ready;
  assign fault  = (state_q != RUN) & (state_q != MEM_WAIT);
  assign run_ok = !frozen & !fault;
  assign br     = run_ok & ex_br_taken;
  assign lu     = run_ok & hazard & !ex_br_taken;
  assign pc_en         = reset | (run_ok & !lu);
  assign if_id_en      = reset | (run_ok & !lu);
  assign id_ex_en      = reset | run_ok;
  assign ex_mem_en     = reset | run_ok;
  assign if_id_flush   = reset | fault | br;
  assign id_ex_flush   = reset | fault | br | lu;
  assign mem_wb_bubble = !reset & (frozen | fault);
  assign state         = state_q;
  assign mem_timeout   = to_q;
  always_comb begin
    state_d = (state_q == RUN) ? (frozen ? MEM_WAIT : RUN) :
              (state_q == MEM_WAIT) ? (mem_ready ? RUN : (cnt_q == 8'(WAIT_MAX)) ? FAULT : MEM_WAIT) :
              FAULT;
    cnt_d   = (state_q == RUN) ? (frozen ? 8'd1 : 8'd0) :
              (state_q == MEM_WAIT) ? (mem_ready ? 8'd0 : (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1) :
              cnt_q;
    to_d    = to_q | ((state_q == MEM_WAIT) & !mem_ready & (cnt_q == 8'(WAIT_MAX)));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] lu_q, br_q, mw_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      lu_q <= '0;
      br_q <= '0;
      mw_q <= '0;
    end else begin
      lu_q <= (lu && lu_q != '1) ? lu_q + 32'd1 : lu_q;
      br_q <= (br && br_q != '1) ? br_q + 32'd1 : br_q;
      mw_q <= (frozen && mw_q != '1) ? mw_q + 32'd1 : mw_q;
    end
  end
  assign lu_stall_cnt = lu_q;
  assign br_flush_cnt = br_q;
  assign mem_wait_cnt = mw_q;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven RUN-state vectors plus hand sequences for stall, freeze, timeout and reset.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_load, ex_br_taken, mem_req, mem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble;
  logic [1:0] state;
  logic mem_timeout;
  logic [6:0] o;
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  pipe_ctrl #(.WAIT_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_load(ex_load), .ex_br_taken(ex_br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_bubble(mem_wb_bubble),
    .state(state), .mem_timeout(mem_timeout)
  );
  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble}
  assign o = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble};
  typedef struct {
    logic [4:0] r1, r2, rd;
    logic u1, u2, ld, br, mq, mr;
    logic [6:0] exp;
  } vec_t;
  vec_t v[10];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic drive(input logic [4:0] r1, r2, rd, input logic u1, u2, ld, br, mq, mr);
    id_rs1 = r1; id_rs2 = r2; ex_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2; ex_load = ld; ex_br_taken = br;
    mem_req = mq; mem_ready = mr;
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    v[0] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111_000};
    v[1] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0011_010};
    v[2] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111_000};
    v[3] = '{5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0011_010};
    v[4] = '{5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111_000};
    v[5] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111_000};
    v[6] = '{5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1111_110};
    v[7] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1111_110};
    v[8] = '{5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 7'b1111_000};
    v[9] = '{5'd4, 5'd4, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7'b0011_010};
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("reset_cycle_outs", 32'(o), 32'b1111_110);
    step();
    reset = 1'b0;
    #1;
    chk("post_reset_state", 32'(state), 0);
    chk("post_reset_timeout", 32'(mem_timeout), 0);
    chk("post_reset_outs", 32'(o), 32'b1111_000);
    for (int i = 0; i < 10; i++) begin
      drive(v[i].r1, v[i].r2, v[i].rd, v[i].u1, v[i].u2, v[i].ld, v[i].br, v[i].mq, v[i].mr);
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(o), 32'(v[i].exp));
      chk($sformatf("vec%0d_state", i), 32'(state), 0);
      step();
    end
    drive(5, 0, 5, 1, 0, 1, 0, 0, 0);
    #1 chk("lu_stall_cycle", 32'(o), 32'b0011_010);
    step();
    drive(5, 0, 0, 1, 0, 0, 0, 0, 0);
    #1 chk("lu_next_cycle", 32'(o), 32'b1111_000);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1 chk("mw_c0_outs", 32'(o), 32'b0000_001);
    chk("mw_c0_state", 32'(state), 0);
    step();
    #1 chk("mw_c1_outs", 32'(o), 32'b0000_001);
    chk("mw_c1_state", 32'(state), 1);
    step();
    drive(5, 0, 5, 1, 0, 1, 1, 1, 0);
    #1 chk("mw_c2_ignore_br_lu", 32'(o), 32'b0000_001);
    chk("mw_c2_state", 32'(state), 1);
    step();
    drive(5, 0, 5, 1, 0, 1, 0, 1, 1);
    #1 chk("mw_release_lu_outs", 32'(o), 32'b0011_010);
    chk("mw_release_state", 32'(state), 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("mw_back_run_state", 32'(state), 0);
    chk("mw_back_run_outs", 32'(o), 32'b1111_000);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step();
    #1 chk("to_last_wait_state", 32'(state), 1);
    chk("to_last_wait_flag", 32'(mem_timeout), 0);
    step();
    #1 chk("to_fault_state", 32'(state), 2);
    chk("to_fault_flag", 32'(mem_timeout), 1);
    chk("to_fault_outs", 32'(o), 32'b0000_111);
    mem_ready = 1'b1;
    step();
    #1 chk("fault_sticky_state", 32'(state), 2);
    chk("fault_sticky_flag", 32'(mem_timeout), 1);
    reset = 1'b1;
    #1 chk("fault_reset_cycle_outs", 32'(o), 32'b1111_110);
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("fault_reset_state", 32'(state), 0);
    chk("fault_reset_flag", 32'(mem_timeout), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    #1 chk("mid_wait_state", 32'(state), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("mid_wait_reset_state", 32'(state), 0);
    chk("mid_wait_reset_cnt", 32'(dut.cnt_q), 0);
    chk("mid_wait_reset_outs", 32'(o), 32'b1111_000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
